// File: rtl/bram_lsu_aligner.sv
// Load/store alignment stage in front of a byte-enable BRAM port: splits misaligned
// accesses into two word accesses and merges/extends load data on the way back.
module bram_lsu_aligner #(
    parameter int CORE       = 0,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_split,
    output logic                  mem_readEnable,
    output logic                  mem_writeEnable,
    output logic [3:0]            mem_writeByteEnable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_writeData,
    input  logic [31:0]           mem_readData
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LD1  = 3'd1,
        S_LD2  = 3'd2,
        S_ST2  = 3'd3,
        S_RESP = 3'd4
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] WORD_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // CORE only tags the instance for debug; it has no effect on the logic.
    if (CORE < 0) begin : g_core_tag
    end

    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic [31:0] res;
        case (size)
            2'd0:    res = {{24{~uns & raw[7]}}, raw[7:0]};
            2'd1:    res = {{16{~uns & raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    state_e                  state_q, state_d;
    logic                    write_q;
    logic [1:0]              size_q;
    logic                    uns_q;
    logic [1:0]              off_q;
    logic [ADDR_WIDTH-1:0]   word_q;
    logic                    split_q;
    logic [3:0]              be2_q;
    logic [31:0]             wdata_q;
    logic [31:0]             w1_q;
    logic                    resp_valid_q, resp_valid_d;
    logic [31:0]             resp_rdata_q, resp_rdata_d;
    logic                    resp_split_q, resp_split_d;

    logic                    accept_s;
    logic [1:0]              off_s;
    logic [ADDR_WIDTH-1:0]   word_s;
    logic [3:0]              mask_s;
    logic [7:0]              be_wide_s;
    logic                    split_s;
    logic [4:0]              sh_s;
    logic [31:0]             wrot_s;
    logic [31:0]             merge_w1_s, merge_w2_s, merged_s;
    logic                    load_done_s;
    logic                    re_s, we_s;
    logic [3:0]              be_s;
    logic [ADDR_WIDTH-1:0]   addr_s;
    logic [31:0]             wd_s;

    assign req_ready = reset & (state_q == S_IDLE);
    assign accept_s  = req_valid & req_ready;
    assign off_s     = req_addr[1:0];
    assign word_s    = req_addr[ADDR_WIDTH+1:2];
    assign sh_s      = {off_s, 3'b000};

    // Request decode: lane mask, split detection, rotated store data.
    always_comb begin
        case (req_size)
            2'd0:    mask_s = 4'b0001;
            2'd1:    mask_s = 4'b0011;
            default: mask_s = 4'b1111;
        endcase
        case (req_size)
            2'd0:    split_s = 1'b0;
            2'd1:    split_s = (off_s == 2'd3);
            default: split_s = (off_s != 2'd0);
        endcase
        // High nibble of the widened shift is exactly the second-access enable set.
        be_wide_s = {4'b0000, mask_s} << off_s;
        wrot_s    = (req_wdata << sh_s) | (req_wdata >> (6'd32 - {1'b0, sh_s}));
    end

    // Next-state, BRAM access drive and response staging.
    always_comb begin
        state_d      = state_q;
        re_s         = 1'b0;
        we_s         = 1'b0;
        be_s         = 4'b0000;
        addr_s       = {ADDR_WIDTH{1'b0}};
        wd_s         = 32'h0000_0000;
        resp_valid_d = 1'b0;
        resp_split_d = 1'b0;
        merge_w1_s   = w1_q;
        merge_w2_s   = 32'h0000_0000;
        load_done_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    addr_s = word_s;
                    if (req_write) begin
                        we_s = 1'b1;
                        be_s = be_wide_s[3:0];
                        wd_s = wrot_s;
                        if (split_s) begin
                            state_d = S_ST2;
                        end else begin
                            state_d      = S_RESP;
                            resp_valid_d = 1'b1;
                        end
                    end else begin
                        re_s    = 1'b1;
                        state_d = S_LD1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LD1: begin
                merge_w1_s = mem_readData;
                if (split_q) begin
                    re_s    = 1'b1;
                    addr_s  = word_q + WORD_ONE;
                    state_d = S_LD2;
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    load_done_s  = 1'b1;
                end
            end
            S_LD2: begin
                merge_w2_s   = mem_readData;
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_split_d = 1'b1;
                load_done_s  = 1'b1;
            end
            S_ST2: begin
                we_s         = 1'b1;
                be_s         = be2_q;
                addr_s       = word_q + WORD_ONE;
                wd_s         = wdata_q;
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_split_d = 1'b1;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        merged_s = 32'({merge_w2_s, merge_w1_s} >> {off_q, 3'b000});
        if (load_done_s && !write_q) begin
            resp_rdata_d = extend_load(merged_s, size_q, uns_q);
        end else begin
            resp_rdata_d = 32'h0000_0000;
        end
    end

    // State, captured request fields, first read word and registered response.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            off_q        <= 2'd0;
            word_q       <= {ADDR_WIDTH{1'b0}};
            split_q      <= 1'b0;
            be2_q        <= 4'b0000;
            wdata_q      <= 32'h0000_0000;
            w1_q         <= 32'h0000_0000;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            resp_split_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept_s) begin
                write_q <= req_write;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                off_q   <= off_s;
                word_q  <= word_s;
                split_q <= split_s;
                be2_q   <= be_wide_s[7:4];
                wdata_q <= wrot_s;
            end
            if (state_q == S_LD1) begin
                w1_q <= mem_readData;
            end
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_split_q <= resp_split_d;
        end
    end

    assign resp_valid          = resp_valid_q;
    assign resp_rdata          = resp_rdata_q;
    assign resp_split          = resp_split_q;
    assign mem_readEnable      = re_s;
    assign mem_writeEnable     = we_s;
    assign mem_writeByteEnable = be_s;
    assign mem_address         = addr_s;
    assign mem_writeData       = wd_s;

endmodule

// File: tb/tb_bram_lsu_aligner.sv
// Scoreboard bench for bram_lsu_aligner: directed requests push expected BRAM
// accesses and responses; a negedge monitor pops and compares them.
module tb_bram_lsu_aligner;
    localparam int AW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [1:0]    req_size = 2'd0;
    logic          req_unsigned = 1'b0;
    logic [AW+1:0] req_addr = '0;
    logic [31:0]   req_wdata = 32'h0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_split;
    logic          mem_readEnable;
    logic          mem_writeEnable;
    logic [3:0]    mem_writeByteEnable;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_writeData;
    logic [31:0]   mem_readData;

    bram_lsu_aligner #(.CORE(0), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_split(resp_split), .mem_readEnable(mem_readEnable),
        .mem_writeEnable(mem_writeEnable), .mem_writeByteEnable(mem_writeByteEnable),
        .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_readData(mem_readData)
    );

    always #5 clock = ~clock;

    // Byte-enable BRAM with one-cycle read latency.
    logic [31:0] ram [256];
    logic        ram_clr = 1'b1;
    always @(posedge clock) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
            mem_readData <= 32'h0;
        end else begin
            if (mem_writeEnable)
                for (int b = 0; b < 4; b++)
                    if (mem_writeByteEnable[b]) ram[mem_address][8*b +: 8] <= mem_writeData[8*b +: 8];
            if (mem_readEnable) mem_readData <= ram[mem_address];
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { logic [31:0] rdata; logic split; int due; } resp_t;
    typedef struct { logic [AW-1:0] addr; logic [3:0] be; logic [31:0] data; } wr_t;
    resp_t         q_resp[$];
    wr_t           q_wr[$];
    logic [AW-1:0] q_rd[$];

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_wr(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
        wr_t w;
        w.addr = a; w.be = be; w.data = d;
        q_wr.push_back(w);
    endtask

    task automatic exp_rd(input logic [AW-1:0] a);
        q_rd.push_back(a);
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        @(negedge clock);
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        ok = req_ready;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [AW+1:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rdata, input logic exp_split,
                         output int t_acc);
        bit    ok;
        int    lat;
        resp_t r;
        req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        wait_ready(ok);
        if (!ok) begin
            req_valid = 1'b0;
            t_acc = -1;
            return;
        end
        t_acc = cyc;
        lat = wr ? (exp_split ? 2 : 1) : (exp_split ? 3 : 2);
        r.rdata = exp_rdata; r.split = exp_split; r.due = cyc + lat;
        q_resp.push_back(r);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    // Monitor: BRAM accesses and responses against the scoreboard queues.
    initial begin
        forever begin
            @(negedge clock);
            if (mem_readEnable && mem_writeEnable) chk("rd_wr_overlap", 32'd1, 32'd0);
            if (mem_readEnable) begin
                if (q_rd.size() == 0) chk("unexpected_read", 32'(mem_address), 32'hFFFF_FFFF);
                else chk("rd_addr", 32'(mem_address), 32'(q_rd.pop_front()));
            end
            if (mem_writeEnable) begin
                if (q_wr.size() == 0) chk("unexpected_write", 32'(mem_address), 32'hFFFF_FFFF);
                else begin
                    wr_t w;
                    w = q_wr.pop_front();
                    chk("wr_addr", 32'(mem_address), 32'(w.addr));
                    chk("wr_be", 32'(mem_writeByteEnable), 32'(w.be));
                    chk("wr_data", mem_writeData, w.data);
                end
            end
            if (resp_valid) begin
                if (q_resp.size() == 0) chk("unexpected_resp", resp_rdata, 32'hFFFF_FFFF);
                else begin
                    resp_t r;
                    r = q_resp.pop_front();
                    chk("resp_rdata", resp_rdata, r.rdata);
                    chk("resp_split", 32'(resp_split), 32'(r.split));
                    chk("resp_cycle", 32'(cyc), 32'(r.due));
                end
            end else begin
                chk("idle_resp_zero", resp_rdata | 32'(resp_split), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

    int t0, t[4];
    bit ok;

    initial begin
        // Reset state.
        repeat (3) @(negedge clock);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_re", 32'(mem_readEnable), 32'd0);
        chk("rst_mem_we", 32'(mem_writeEnable), 32'd0);
        chk("rst_mem_be", 32'(mem_writeByteEnable), 32'd0);
        chk("rst_mem_addr_data", 32'(mem_address) | mem_writeData, 32'd0);
        ram_clr = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("ready_after_reset", 32'(req_ready), 32'd1);
        @(posedge clock); #1;

        // Aligned store then load.
        exp_wr(8'd4, 4'b1111, 32'hDEADBEEF);
        issue(1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0, t0);
        exp_rd(8'd4);
        issue(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, t0);

        // Byte/half extension from word 4 = 0x80FF7F01.
        exp_wr(8'd4, 4'b1111, 32'h80FF7F01);
        issue(1'b1, 2'd2, 1'b0, 10'h010, 32'h80FF7F01, 32'h0, 1'b0, t0);
        exp_rd(8'd4); issue(1'b0, 2'd0, 1'b0, 10'h013, 32'h0, 32'hFFFFFF80, 1'b0, t0);
        exp_rd(8'd4); issue(1'b0, 2'd1, 1'b1, 10'h012, 32'h0, 32'h000080FF, 1'b0, t0);
        exp_rd(8'd4); issue(1'b0, 2'd0, 1'b0, 10'h010, 32'h0, 32'h00000001, 1'b0, t0);
        exp_rd(8'd4); issue(1'b0, 2'd1, 1'b0, 10'h011, 32'h0, 32'hFFFFFF7F, 1'b0, t0);
        exp_rd(8'd4); issue(1'b0, 2'd0, 1'b1, 10'h012, 32'h0, 32'h000000FF, 1'b0, t0);

        // Split word store and reload.
        exp_wr(8'd3, 4'b1110, 32'h22334411);
        exp_wr(8'd4, 4'b0001, 32'h22334411);
        issue(1'b1, 2'd2, 1'b0, 10'h00D, 32'h11223344, 32'h0, 1'b1, t0);
        exp_rd(8'd3); exp_rd(8'd4);
        issue(1'b0, 2'd2, 1'b0, 10'h00D, 32'h0, 32'h11223344, 1'b1, t0);

        // Top-word wrap-around.
        exp_wr(8'd255, 4'b1000, 32'hCD0000AB);
        exp_wr(8'd0, 4'b0001, 32'hCD0000AB);
        issue(1'b1, 2'd1, 1'b0, 10'h3FF, 32'h0000ABCD, 32'h0, 1'b1, t0);
        exp_rd(8'd255); exp_rd(8'd0);
        issue(1'b0, 2'd1, 1'b0, 10'h3FF, 32'h0, 32'hFFFFABCD, 1'b1, t0);
        exp_rd(8'd255); exp_rd(8'd0);
        issue(1'b0, 2'd1, 1'b1, 10'h3FF, 32'h0, 32'h0000ABCD, 1'b1, t0);

        // Byte store with junk upper bits, aligned-in-word half at offset 1, reserved size.
        exp_wr(8'h40, 4'b0100, 32'hFF5AFFFF);
        issue(1'b1, 2'd0, 1'b0, 10'h102, 32'hFFFFFF5A, 32'h0, 1'b0, t0);
        exp_rd(8'h40); issue(1'b0, 2'd0, 1'b1, 10'h102, 32'h0, 32'h0000005A, 1'b0, t0);
        exp_wr(8'd8, 4'b0110, 32'h00123400);
        issue(1'b1, 2'd1, 1'b0, 10'h021, 32'h00001234, 32'h0, 1'b0, t0);
        exp_rd(8'd8); issue(1'b0, 2'd1, 1'b0, 10'h021, 32'h0, 32'h00001234, 1'b0, t0);
        exp_rd(8'd4); issue(1'b0, 2'd3, 1'b0, 10'h010, 32'h0, 32'h80FF7F11, 1'b0, t0);

        // Reset while in LD1 of a split load: no response, outputs drop at once.
        exp_rd(8'd3);
        req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 10'h00D;
        req_valid = 1'b1;
        wait_ready(ok);
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("ld1_second_read", {31'd0, mem_readEnable} | (32'(mem_address) << 8), 32'h0000_0401);
        #1 reset = 1'b0;
        #1;
        chk("midrst_mem_en", 32'({mem_readEnable, mem_writeEnable}), 32'd0);
        chk("midrst_mem_be_addr", 32'(mem_writeByteEnable) | 32'(mem_address), 32'd0);
        chk("midrst_mem_wdata", mem_writeData, 32'd0);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        repeat (2) @(negedge clock);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("ready_after_midrst", 32'(req_ready), 32'd1);
        @(posedge clock); #1;
        exp_rd(8'd4); issue(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 32'h80FF7F11, 1'b0, t0);

        // Back-to-back aligned loads with req_valid held high.
        exp_rd(8'd4); exp_rd(8'd3); exp_rd(8'd8); exp_rd(8'h40);
        issue(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 32'h80FF7F11, 1'b0, t[0]);
        issue(1'b0, 2'd2, 1'b0, 10'h00C, 32'h0, 32'h22334400, 1'b0, t[1]);
        issue(1'b0, 2'd2, 1'b0, 10'h020, 32'h0, 32'h00123400, 1'b0, t[2]);
        issue(1'b0, 2'd2, 1'b0, 10'h100, 32'h0, 32'h005A0000, 1'b0, t[3]);
        for (int i = 1; i < 4; i++) chk("b2b_accept_gap", 32'(t[i] - t[i-1]), 32'd3);

        repeat (6) @(negedge clock);
        chk("pending_resps", 32'(q_resp.size()), 32'd0);
        chk("pending_reads", 32'(q_rd.size()), 32'd0);
        chk("pending_writes", 32'(q_wr.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
